// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR width, seed, successor function and checker state enum
package lfsr_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h8A;

  typedef enum logic {
    SYNC   = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  // Right shift with feedback into bit 7; shared with the pattern generator.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
    return {x[7] ^ x[6] ^ x[4] ^ x[1], x[7:1]};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear that keeps a coincident event
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/lfsr_checker_8bit.sv
// rtl/lfsr_checker_8bit.sv - self-synchronising 8-bit LFSR sequence checker with error and word counters
module lfsr_checker_8bit
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              din_valid,
  input  logic [LFSR_W-1:0] din,
  input  logic              clr_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  word_count
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic [LFSR_W-1:0] pred_q, pred_d;
  logic [3:0]        match_cnt_q, match_cnt_d;
  logic [3:0]        miss_cnt_q, miss_cnt_d;
  logic              err_pulse_q, err_pulse_d;
  logic              err_inc;
  logic              word_inc;
  logic [3:0]        match_inc;
  logic [3:0]        miss_inc;
  logic              din_nonzero;

  assign match_inc   = match_cnt_q + 4'd1;
  assign miss_inc    = miss_cnt_q + 4'd1;
  assign din_nonzero = (din != '0);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    pred_d      = pred_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    word_inc    = 1'b0;

    if (din_valid) begin
      case (state_q)
        SYNC: begin
          prev_d      = din;
          have_prev_d = din_nonzero;
          // 8'h00 is the lock-up value and must never credit a match.
          if (have_prev_q && din_nonzero && (din == lfsr_next(prev_q))) begin
            match_cnt_d = match_inc;
            if (match_inc == LOCK_TGT) begin
              state_d    = LOCKED;
              pred_d     = lfsr_next(din);
              miss_cnt_d = 4'd0;
            end
          end else begin
            match_cnt_d = 4'd0;
          end
        end
        LOCKED: begin
          // Prediction free-wheels so one corrupted word costs exactly one error.
          pred_d   = lfsr_next(pred_q);
          word_inc = 1'b1;
          if (din != pred_q) begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            miss_cnt_d  = miss_inc;
            if (miss_inc == LOSS_TGT) begin
              state_d     = SYNC;
              match_cnt_d = 4'd0;
              prev_d      = din;
              have_prev_d = din_nonzero;
            end
          end else begin
            miss_cnt_d = 4'd0;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SYNC;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      pred_q      <= '0;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      pred_q      <= pred_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (err_inc),
    .clr     (clr_cnt),
    .cnt     (err_count)
  );

  sat_counter #(.W(CNT_W)) u_word_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (word_inc),
    .clr     (clr_cnt),
    .cnt     (word_count)
  );

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_lfsr_checker_8bit.sv
// tb/tb_lfsr_checker_8bit.sv - scoreboard bench for lfsr_checker_8bit
module tb_lfsr_checker_8bit;
  import lfsr_pkg::*;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 4;
  localparam int MAXC   = 65535;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        din_valid = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        clr_cnt = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_count, word_count;
  logic        locked_b, err_pulse_b;
  logic [7:0]  err_count_b, word_count_b;

  always #5 clk = ~clk;

  lfsr_checker_8bit dut (
    .clk(clk), .reset_n(reset_n), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .word_count(word_count)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  lfsr_checker_8bit #(.CNT_W(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
    .locked(locked_b), .err_pulse(err_pulse_b), .err_count(err_count_b), .word_count(word_count_b)
  );

  typedef struct packed {
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] word_count;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   pulses_seen = 0;
  bit   locked_seen = 0;

  bit         m_locked, m_pulse, m_have;
  logic [7:0] m_prev, m_pred, g;
  int         m_match, m_miss, m_ec, m_wc;

  function automatic logic [7:0] ref_next(input logic [7:0] x);
    return {^(x & 8'hD2), x[7:1]};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_pulse = 0; m_have = 0;
    m_prev = 8'h00; m_pred = 8'h00;
    m_match = 0; m_miss = 0; m_ec = 0; m_wc = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit c);
    bit ie, iw, ok;
    ie = 0; iw = 0; m_pulse = 0;
    if (v) begin
      if (!m_locked) begin
        ok = m_have && (d != 8'h00) && (d == ref_next(m_prev));
        m_prev = d;
        m_have = (d != 8'h00);
        if (ok) begin
          m_match++;
          if (m_match == LOCK_N) begin
            m_locked = 1; m_pred = ref_next(d); m_miss = 0;
          end
        end else begin
          m_match = 0;
        end
      end else begin
        iw = 1;
        if (d != m_pred) begin
          m_pulse = 1; ie = 1; m_miss++;
          if (m_miss == LOSS_N) begin
            m_locked = 0; m_match = 0; m_prev = d; m_have = (d != 8'h00);
          end
        end else begin
          m_miss = 0;
        end
        m_pred = ref_next(m_pred);
      end
    end
    if (c) begin
      m_ec = int'(ie); m_wc = int'(iw);
    end else begin
      if (ie && m_ec < MAXC) m_ec++;
      if (iw && m_wc < MAXC) m_wc++;
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit c);
    exp_t e;
    din_valid = v; din = d; clr_cnt = c;
    model_step(v, d, c);
    e.locked = m_locked; e.err_pulse = m_pulse;
    e.err_count = 16'(m_ec); e.word_count = 16'(m_wc);
    exp_q.push_back(e);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    pulses_seen += int'(err_pulse);
    locked_seen |= locked;
    n_checks += 4;
    if (locked !== e.locked) begin
      n_errors++; $display("FAIL sb_locked t=%0t got=%b exp=%b", $time, locked, e.locked);
    end
    if (err_pulse !== e.err_pulse) begin
      n_errors++; $display("FAIL sb_err_pulse t=%0t got=%b exp=%b", $time, err_pulse, e.err_pulse);
    end
    if (err_count !== e.err_count) begin
      n_errors++; $display("FAIL sb_err_count t=%0t got=%h exp=%h", $time, err_count, e.err_count);
    end
    if (word_count !== e.word_count) begin
      n_errors++; $display("FAIL sb_word_count t=%0t got=%h exp=%h", $time, word_count, e.word_count);
    end
  endtask

  task automatic seed_lock(input string tag);
    g = LFSR_SEED;
    for (int i = 1; i <= 5; i++) begin
      step(1, g, 0);
      g = ref_next(g);
      if (i == 4) begin
        n_checks++;
        if (locked !== 1'b0) begin n_errors++; $display("FAIL %s_early got=%b exp=0", tag, locked); end
      end
      if (i == 5) begin
        n_checks++;
        if (locked !== 1'b1) begin n_errors++; $display("FAIL %s_5th got=%b exp=1", tag, locked); end
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks += 4;
    if (locked !== 1'b0) begin n_errors++; $display("FAIL rst_locked got=%b exp=0", locked); end
    if (err_pulse !== 1'b0) begin n_errors++; $display("FAIL rst_err_pulse got=%b exp=0", err_pulse); end
    if (err_count !== 16'h0) begin n_errors++; $display("FAIL rst_err_count got=%h exp=0", err_count); end
    if (word_count !== 16'h0) begin n_errors++; $display("FAIL rst_word_count got=%h exp=0", word_count); end
    reset_n = 1'b1;
  endtask

  task automatic test_lock_stream();
    seed_lock("lock");
    pulses_seen = 0;
    repeat (300) begin step(1, g, 0); g = ref_next(g); end
    n_checks += 3;
    if (pulses_seen != 0) begin n_errors++; $display("FAIL stream_pulses got=%0d exp=0", pulses_seen); end
    if (word_count !== 16'd300) begin n_errors++; $display("FAIL stream_words got=%0d exp=300", word_count); end
    if (err_count !== 16'd0) begin n_errors++; $display("FAIL stream_errs got=%0d exp=0", err_count); end
  endtask

  task automatic test_single_error();
    pulses_seen = 0;
    step(1, g ^ 8'h01, 0);
    g = ref_next(g);
    n_checks++;
    if (err_pulse !== 1'b1) begin n_errors++; $display("FAIL single_pulse got=%b exp=1", err_pulse); end
    repeat (20) begin step(1, g, 0); g = ref_next(g); end
    n_checks += 3;
    if (pulses_seen != 1) begin n_errors++; $display("FAIL single_pulses got=%0d exp=1", pulses_seen); end
    if (err_count !== 16'd1) begin n_errors++; $display("FAIL single_errs got=%0d exp=1", err_count); end
    if (locked !== 1'b1) begin n_errors++; $display("FAIL single_locked got=%b exp=1", locked); end
  endtask

  task automatic test_burst_loss();
    logic [7:0] bad;
    step(1, g, 1);
    g = ref_next(g);
    pulses_seen = 0;
    for (int i = 0; i < 4; i++) begin
      bad = (i < 3) ? (g ^ 8'hFF) : ((g != 8'h00) ? 8'h00 : 8'hFF);
      step(1, bad, 0);
      g = ref_next(g);
      if (i == 2) begin
        n_checks++;
        if (locked !== 1'b1) begin n_errors++; $display("FAIL burst_hold got=%b exp=1", locked); end
      end
      if (i == 3) begin
        n_checks++;
        if (locked !== 1'b0) begin n_errors++; $display("FAIL burst_drop got=%b exp=0", locked); end
      end
    end
    n_checks += 2;
    if (pulses_seen != 4) begin n_errors++; $display("FAIL burst_pulses got=%0d exp=4", pulses_seen); end
    if (err_count !== 16'd4) begin n_errors++; $display("FAIL burst_errs got=%0d exp=4", err_count); end
    seed_lock("relock");
  endtask

  task automatic test_saturation();
    step(1, g, 1);
    g = ref_next(g);
    repeat (85) begin
      repeat (3) begin step(1, g ^ 8'hFF, 0); g = ref_next(g); end
      step(1, g, 0);
      g = ref_next(g);
    end
    n_checks += 2;
    if (err_count_b !== 8'hFF) begin n_errors++; $display("FAIL sat_reach got=%h exp=ff", err_count_b); end
    if (locked_b !== 1'b1) begin n_errors++; $display("FAIL sat_locked_b got=%b exp=1", locked_b); end
    step(1, g ^ 8'hFF, 0);
    g = ref_next(g);
    n_checks += 3;
    if (err_count_b !== 8'hFF) begin n_errors++; $display("FAIL sat_hold got=%h exp=ff", err_count_b); end
    if (word_count_b !== 8'hFF) begin n_errors++; $display("FAIL sat_words_b got=%h exp=ff", word_count_b); end
    if (err_pulse_b !== 1'b1) begin n_errors++; $display("FAIL sat_pulse_b got=%b exp=1", err_pulse_b); end
    step(1, g, 0);
    g = ref_next(g);
    step(1, g ^ 8'hFF, 1);
    g = ref_next(g);
    n_checks += 3;
    if (err_count !== 16'd1) begin n_errors++; $display("FAIL clr_err_a got=%h exp=1", err_count); end
    if (err_count_b !== 8'd1) begin n_errors++; $display("FAIL clr_err_b got=%h exp=1", err_count_b); end
    if (word_count_b !== 8'd1) begin n_errors++; $display("FAIL clr_words_b got=%h exp=1", word_count_b); end
    repeat (5) begin step(1, g, 0); g = ref_next(g); end
  endtask

  task automatic test_zero_stream();
    din_valid = 1'b0;
    reset_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    locked_seen = 0;
    repeat (50) step(1, 8'h00, 0);
    n_checks += 3;
    if (locked_seen) begin n_errors++; $display("FAIL zero_locked got=1 exp=0"); end
    if (err_count !== 16'd0) begin n_errors++; $display("FAIL zero_errs got=%0d exp=0", err_count); end
    if (word_count !== 16'd0) begin n_errors++; $display("FAIL zero_words got=%0d exp=0", word_count); end
  endtask

  task automatic test_gaps();
    int nv;
    bit v;
    seed_lock("gap_lock");
    nv = 0;
    pulses_seen = 0;
    repeat (120) begin
      v = ($urandom_range(0, 1) == 1);
      if (v) begin
        step(1, g, 0); g = ref_next(g); nv++;
      end else begin
        step(0, 8'($urandom), 0);
      end
    end
    n_checks += 3;
    if (word_count !== 16'(nv)) begin n_errors++; $display("FAIL gap_words got=%0d exp=%0d", word_count, nv); end
    if (err_count !== 16'd0) begin n_errors++; $display("FAIL gap_errs got=%0d exp=0", err_count); end
    if (pulses_seen != 0) begin n_errors++; $display("FAIL gap_pulses got=%0d exp=0", pulses_seen); end
  endtask

  task automatic test_async_reset();
    reset_n = 1'b0;
    #1;
    n_checks += 4;
    if (locked !== 1'b0) begin n_errors++; $display("FAIL arst_locked got=%b exp=0", locked); end
    if (err_pulse !== 1'b0) begin n_errors++; $display("FAIL arst_err_pulse got=%b exp=0", err_pulse); end
    if (err_count !== 16'h0) begin n_errors++; $display("FAIL arst_err_count got=%h exp=0", err_count); end
    if (word_count !== 16'h0) begin n_errors++; $display("FAIL arst_word_count got=%h exp=0", word_count); end
    #2;
    reset_n = 1'b1;
    model_reset();
    seed_lock("arst_relock");
    repeat (10) begin step(1, g, 0); g = ref_next(g); end
  endtask

  initial begin
    test_reset();
    test_lock_stream();
    test_single_error();
    test_burst_loss();
    test_saturation();
    test_zero_stream();
    test_gaps();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
